// File: rtl/imm_seq_pkg.sv
// Shared definitions for the ID immediate sequencer: extension modes,
// MIPS32 opcode/funct constants, buffer states and the buffered entry layout.
package imm_seq_pkg;

  typedef enum logic [1:0] {
    MODE_SIGN16 = 2'b00,
    MODE_ZERO16 = 2'b01,
    MODE_LUI    = 2'b10,
    MODE_SHAMT  = 2'b11
  } imm_mode_e;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b10
  } buf_state_e;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0A;
  localparam logic [5:0] OP_SLTIU   = 6'h0B;
  localparam logic [5:0] OP_ANDI    = 6'h0C;
  localparam logic [5:0] OP_ORI     = 6'h0D;
  localparam logic [5:0] OP_XORI    = 6'h0E;
  localparam logic [5:0] OP_LUI     = 6'h0F;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LWL     = 6'h22;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_LWR     = 6'h26;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SWL     = 6'h2A;
  localparam logic [5:0] OP_SW      = 6'h2B;
  localparam logic [5:0] OP_SWR     = 6'h2E;

  localparam logic [5:0] FN_SLL     = 6'h00;
  localparam logic [5:0] FN_SRL     = 6'h02;
  localparam logic [5:0] FN_SRA     = 6'h03;

  typedef struct packed {
    logic [31:0] imm;
    imm_mode_e   mode;
    logic        use_imm;
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

endpackage

// File: rtl/id_imm_decode.sv
// Combinational immediate decode: instruction word -> extended immediate,
// extension mode and use flag. Unrecognised encodings yield all-zero outputs.
module id_imm_decode
  import imm_seq_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm,
  output logic [1:0]  mode,
  output logic        use_imm
);

  logic [5:0] w_op;
  logic [5:0] w_funct;
  imm_mode_e  w_mode;

  assign w_op    = instr[31:26];
  assign w_funct = instr[5:0];
  assign mode    = w_mode;

  always_comb begin
    imm     = '0;
    w_mode  = MODE_SIGN16;
    use_imm = 1'b0;
    case (w_op)
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
      OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR,
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ, OP_REGIMM: begin
        imm     = {{16{instr[15]}}, instr[15:0]};
        w_mode  = MODE_SIGN16;
        use_imm = 1'b1;
      end
      OP_ANDI, OP_ORI, OP_XORI: begin
        imm     = {16'b0, instr[15:0]};
        w_mode  = MODE_ZERO16;
        use_imm = 1'b1;
      end
      OP_LUI: begin
        imm     = {instr[15:0], 16'b0};
        w_mode  = MODE_LUI;
        use_imm = 1'b1;
      end
      OP_SPECIAL: begin
        if (w_funct == FN_SLL || w_funct == FN_SRL || w_funct == FN_SRA) begin
          imm     = {27'b0, instr[10:6]};
          w_mode  = MODE_SHAMT;
          use_imm = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/id_imm_sequencer.sv
// Two-entry (main + skid) decoded-immediate buffer between IF and EX.
// Optional stall counter enabled by defining IMM_SEQ_PERF_EN.
module id_imm_sequencer
  import imm_seq_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_imm,
  output logic [1:0]  out_mode,
  output logic        out_use_imm,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr
`ifdef IMM_SEQ_PERF_EN
  ,
  output logic [15:0] perf_stall_cnt
`endif
);

  buf_state_e r_state;
  buf_state_e w_next_state;
  entry_t     r_main;
  entry_t     r_skid;
  entry_t     w_dec;
  logic [1:0] w_dec_mode;
  logic       w_in_fire;
  logic       w_out_fire;
  logic       w_load_main_in;
  logic       w_load_skid_in;
  logic       w_main_from_skid;

  id_imm_decode u_decode (
    .instr   (in_instr),
    .imm     (w_dec.imm),
    .mode    (w_dec_mode),
    .use_imm (w_dec.use_imm)
  );

  assign w_dec.mode  = imm_mode_e'(w_dec_mode);
  assign w_dec.pc    = in_pc;
  assign w_dec.instr = in_instr;

  assign in_ready    = (r_state != ST_TWO);
  assign out_valid   = (r_state != ST_EMPTY);
  assign out_imm     = r_main.imm;
  assign out_mode    = r_main.mode;
  assign out_use_imm = r_main.use_imm;
  assign out_pc      = r_main.pc;
  assign out_instr   = r_main.instr;

  assign w_in_fire   = in_valid && in_ready;
  assign w_out_fire  = out_valid && out_ready;

  always_comb begin
    w_next_state     = r_state;
    w_load_main_in   = 1'b0;
    w_load_skid_in   = 1'b0;
    w_main_from_skid = 1'b0;
    if (flush) begin
      w_next_state = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_next_state   = ST_ONE;
            w_load_main_in = 1'b1;
          end
        end
        ST_ONE: begin
          // Simultaneous in/out replaces main directly; skid stays unused.
          if (w_in_fire && w_out_fire) begin
            w_load_main_in = 1'b1;
          end else if (w_in_fire) begin
            w_next_state   = ST_TWO;
            w_load_skid_in = 1'b1;
          end else if (w_out_fire) begin
            w_next_state = ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (w_out_fire) begin
            w_next_state     = ST_ONE;
            w_main_from_skid = 1'b1;
          end
        end
        default: w_next_state = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= ST_EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_load_main_in) begin
        r_main <= w_dec;
      end else if (w_main_from_skid) begin
        r_main <= r_skid;
      end
      if (w_load_skid_in) begin
        r_skid <= w_dec;
      end
    end
  end

`ifdef IMM_SEQ_PERF_EN
  logic [15:0] r_stall_cnt;

  assign perf_stall_cnt = r_stall_cnt;

  // Cleared only by reset; flush leaves the running total intact.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_stall_cnt <= '0;
    end else if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_imm_sequencer.sv
// Self-checking bench for id_imm_sequencer: decode table, directed corner
// sequences and randomized traffic against a queue-based reference model.
module tb_id_imm_sequencer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_imm;
  logic [1:0]  out_mode;
  logic        out_use_imm;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
`ifdef IMM_SEQ_PERF_EN
  logic [15:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  id_imm_sequencer dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_imm     (out_imm),
    .out_mode    (out_mode),
    .out_use_imm (out_use_imm),
    .out_pc      (out_pc),
    .out_instr   (out_instr)
`ifdef IMM_SEQ_PERF_EN
    ,
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  typedef struct {
    logic [31:0] imm;
    logic [1:0]  mode;
    logic        use_imm;
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] imm;
    logic [1:0]  mode;
    logic        use_imm;
  } vec_t;

  exp_t model_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference decode written from the instruction-class lists.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    int op;
    int fn;
    op = int'(ins[31:26]);
    fn = int'(ins[5:0]);
    e.imm = 32'd0; e.mode = 2'd0; e.use_imm = 1'b0; e.pc = pc; e.instr = ins;
    if (op inside {8, 9, 10, 11, 'h20, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26,
                   'h28, 'h29, 'h2A, 'h2B, 'h2E, 4, 5, 6, 7, 1}) begin
      e.imm = 32'(signed'(ins[15:0])); e.mode = 2'd0; e.use_imm = 1'b1;
    end else if (op inside {'hC, 'hD, 'hE}) begin
      e.imm = 32'(ins[15:0]); e.mode = 2'd1; e.use_imm = 1'b1;
    end else if (op == 'hF) begin
      e.imm = 32'(ins[15:0]) * 32'd65536; e.mode = 2'd2; e.use_imm = 1'b1;
    end else if (op == 0 && fn inside {0, 2, 3}) begin
      e.imm = 32'(ins[10:6]); e.mode = 2'd3; e.use_imm = 1'b1;
    end
    return e;
  endfunction

  task automatic model_check();
    chk("out_valid", 32'(out_valid), 32'(model_q.size() > 0));
    chk("in_ready", 32'(in_ready), 32'(model_q.size() < 2));
    if (model_q.size() > 0) begin
      chk("out_imm", out_imm, model_q[0].imm);
      chk("out_mode", 32'(out_mode), 32'(model_q[0].mode));
      chk("out_use_imm", 32'(out_use_imm), 32'(model_q[0].use_imm));
      chk("out_pc", out_pc, model_q[0].pc);
      chk("out_instr", out_instr, model_q[0].instr);
    end
  endtask

  // Drive one cycle, advance the model at the edge, check at the falling edge.
  task automatic cycle(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    bit can_in;
    in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    @(posedge clk);
    can_in = model_q.size() < 2;
    if (!resetn || fl) begin
      model_q.delete();
    end else begin
      if (ordy && model_q.size() > 0) void'(model_q.pop_front());
      if (iv && can_in) model_q.push_back(ref_decode(ins, pc));
    end
    @(negedge clk);
    model_check();
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_imm"}, out_imm, 32'd0);
    chk({tag, "_out_mode"}, 32'(out_mode), 32'd0);
    chk({tag, "_out_use_imm"}, 32'(out_use_imm), 32'd0);
    chk({tag, "_out_pc"}, out_pc, 32'd0);
    chk({tag, "_out_instr"}, out_instr, 32'd0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] ops [20];
    logic [31:0] ins;
    ops = '{6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h04, 6'h07, 6'h08, 6'h09, 6'h0B,
            6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h10, 6'h23, 6'h24, 6'h2B, 6'h2E, 6'h3F};
    ins = $urandom;
    ins[31:26] = ops[$urandom_range(19)];
    if (ins[31:26] == 6'h00 && $urandom_range(1) == 1) ins[5:0] = 6'($urandom_range(3));
    return ins;
  endfunction

  vec_t tbl[14];

  initial begin
    tbl[0]  = '{32'h20008000, 32'hFFFF8000, 2'd0, 1'b1};  // ADDI 0x8000
    tbl[1]  = '{32'h34008000, 32'h00008000, 2'd1, 1'b1};  // ORI
    tbl[2]  = '{32'h3C001234, 32'h12340000, 2'd2, 1'b1};  // LUI
    tbl[3]  = '{32'h000007C0, 32'h0000001F, 2'd3, 1'b1};  // SLL 31
    tbl[4]  = '{32'h00221821, 32'h00000000, 2'd0, 1'b0};  // ADDU
    tbl[5]  = '{32'hAC22FFFC, 32'hFFFFFFFC, 2'd0, 1'b1};  // SW -4
    tbl[6]  = '{32'h10227FFF, 32'h00007FFF, 2'd0, 1'b1};  // BEQ
    tbl[7]  = '{32'h00031143, 32'h00000005, 2'd3, 1'b1};  // SRA 5
    tbl[8]  = '{32'h3862FFFF, 32'h0000FFFF, 2'd1, 1'b1};  // XORI
    tbl[9]  = '{32'h0421FFFF, 32'hFFFFFFFF, 2'd0, 1'b1};  // REGIMM
    tbl[10] = '{32'h08001234, 32'h00000000, 2'd0, 1'b0};  // J
    tbl[11] = '{32'h000007C4, 32'h00000000, 2'd0, 1'b0};  // SLLV
    tbl[12] = '{32'h90008001, 32'hFFFF8001, 2'd0, 1'b1};  // LBU
    tbl[13] = '{32'h00000002, 32'h00000000, 2'd3, 1'b1};  // SRL 0

    resetn = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero_outputs("reset");
    resetn = 1'b1;
    model_q.delete();

    // Decode table, streamed with out_ready high: each entry visible one cycle later.
    for (int i = 0; i < 14; i++) begin
      cycle(1'b1, tbl[i].instr, 32'h1000 + 32'(i * 4), 1'b1, 1'b0);
      chk($sformatf("tbl%0d_imm", i), out_imm, tbl[i].imm);
      chk($sformatf("tbl%0d_mode", i), 32'(out_mode), 32'(tbl[i].mode));
      chk($sformatf("tbl%0d_use", i), 32'(out_use_imm), 32'(tbl[i].use_imm));
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Backpressure: two accepted, third held until drain.
    cycle(1'b1, 32'h20000001, 32'h2000, 1'b0, 1'b0);
    chk("bp_ready_after1", 32'(in_ready), 32'd1);
    cycle(1'b1, 32'h20000002, 32'h2004, 1'b0, 1'b0);
    chk("bp_ready_after2", 32'(in_ready), 32'd0);
    cycle(1'b1, 32'h20000003, 32'h2008, 1'b0, 1'b0);
    chk("bp_hold_pc", out_pc, 32'h2000);
    cycle(1'b1, 32'h20000003, 32'h2008, 1'b1, 1'b0);
    chk("bp_second_pc", out_pc, 32'h2004);
    cycle(1'b1, 32'h20000003, 32'h2008, 1'b1, 1'b0);
    chk("bp_third_pc", out_pc, 32'h2008);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

    // Flush in TWO with coincident in/out transfers.
    cycle(1'b1, 32'h34000011, 32'h3000, 1'b0, 1'b0);
    cycle(1'b1, 32'h34000022, 32'h3004, 1'b0, 1'b0);
    cycle(1'b1, 32'h34000033, 32'h3008, 1'b1, 1'b1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    chk("flush_dropped", 32'(out_valid), 32'd0);

    // Flush while accepting into EMPTY: instruction discarded.
    cycle(1'b1, 32'h3C00ABCD, 32'h3100, 1'b1, 1'b1);
    chk("flush_empty_drop", 32'(out_valid), 32'd0);

    // Reset while holding two entries.
    cycle(1'b1, 32'h3C00AAAA, 32'h4000, 1'b0, 1'b0);
    cycle(1'b1, 32'h3C00BBBB, 32'h4004, 1'b0, 1'b0);
    resetn = 1'b0;
    cycle(1'b1, 32'h3C00CCCC, 32'h4008, 1'b1, 1'b0);
    chk_zero_outputs("midreset");
    resetn = 1'b1;

    // Randomized traffic with occasional flush.
    for (int n = 0; n < 3000; n++) begin
      cycle(1'($urandom_range(3) != 0), rand_instr(), $urandom,
            1'($urandom_range(2) != 0), 1'($urandom_range(40) == 0));
    end
    cycle(1'b0, '0, '0, 1'b1, 1'b0);
    cycle(1'b0, '0, '0, 1'b1, 1'b0);

`ifdef IMM_SEQ_PERF_EN
    resetn = 1'b0;
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    resetn = 1'b1;
    chk("perf_after_reset0", 32'(perf_stall_cnt), 32'd0);
    cycle(1'b1, 32'h20000001, 32'h5000, 1'b0, 1'b0);
    in_valid = 1'b0;
    repeat (70000) @(posedge clk);
    @(negedge clk);
    chk("perf_saturated", 32'(perf_stall_cnt), 32'hFFFF);
    cycle(1'b0, '0, '0, 1'b0, 1'b1);
    chk("perf_after_flush", 32'(perf_stall_cnt), 32'hFFFF);
    resetn = 1'b0;
    cycle(1'b0, '0, '0, 1'b0, 1'b0);
    resetn = 1'b1;
    chk("perf_after_reset", 32'(perf_stall_cnt), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/id_imm_sequencer.md
ID_IMM_SEQUENCER -- requirements
Module: id_imm_sequencer

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 resetn  input  1  reset, synchronous, active-low.
REQ-003 in_valid  input  1  upstream (IF) holds a valid instruction.
REQ-004 in_ready  output  1  block can accept an instruction this cycle.
REQ-005 in_instr  input  32  MIPS32 instruction word.
REQ-006 in_pc  input  32  PC of in_instr.
REQ-007 flush  input  1  discard all buffered instructions (branch/exception redirect).
REQ-008 out_valid  output  1  out_* fields hold a decoded entry.
REQ-009 out_ready  input  1  downstream (EX) accepts the entry this cycle.
REQ-010 out_imm  output  32  extended immediate.
REQ-011 out_mode  output  2  extension mode applied: 00 sign16, 01 zero16, 10 lui-upper, 11 zero shamt5.
REQ-012 out_use_imm  output  1  instruction consumes out_imm.
REQ-013 out_pc  output  32  PC carried with the entry.
REQ-014 out_instr  output  32  instruction carried with the entry.

Function
REQ-015 Decode SHALL be: ADDI/ADDIU/SLTI/SLTIU/loads/stores/BEQ/BNE/BLEZ/BGTZ/REGIMM -> mode 00, imm={16{i[15]},i[15:0]}; ANDI/ORI/XORI -> 01, imm={16'b0,i[15:0]}; LUI -> 10, imm={i[15:0],16'b0}; SPECIAL funct SLL/SRL/SRA -> 11, imm={27'b0,i[10:6]}.
REQ-016 All other encodings SHALL give out_use_imm=0, out_mode=00, out_imm=0.
REQ-017 Decode SHALL happen on the input side; stored entries hold decoded fields, outputs driven directly from registers (no combinational in->out path).
REQ-018 Transfer in SHALL occur when in_valid&&in_ready; transfer out when out_valid&&out_ready.
REQ-019 Buffer SHALL be 2 entries (main, skid), states EMPTY, ONE, TWO; in_ready = (state!=TWO), registered.
REQ-020 EMPTY: in xfer -> ONE (entry visible next cycle; latency 1).
REQ-021 ONE: in only -> TWO; out only -> EMPTY; in+out same cycle -> ONE with new entry in main.
REQ-022 TWO: out xfer -> ONE, skid moves to main; no in xfer possible.
REQ-023 Order SHALL be strictly FIFO; no entry dropped or duplicated under any in/out_ready pattern.
REQ-024 out_* fields SHALL remain stable while out_valid && !out_ready.
REQ-025 flush SHALL force EMPTY next cycle, dominating simultaneous in/out transfers; an in_valid coincident with flush is discarded (in_ready may read 1, instruction still dropped).
REQ-026 out_valid=0 in the cycle after flush; in_ready=1 in that cycle.

Reset
REQ-027 resetn=0 at a clk edge SHALL force EMPTY: out_valid=0, in_ready=1 next cycle, out_imm/out_pc/out_instr=0, out_mode=00, out_use_imm=0.
REQ-028 Reset mid-operation SHALL discard both entries with no output transfer.

Configuration
REQ-029 Macro IMM_SEQ_PERF_EN defined: port perf_stall_cnt output 16 SHALL exist, counting cycles with out_valid&&!out_ready, saturating at 0xFFFF, cleared by reset only (not by flush).
REQ-030 Macro undefined: port and counter SHALL be absent; all other behaviour identical.

Structure
REQ-031 Shared package/header imm_seq_pkg SHALL hold mode encodings (00..11), opcode and funct constants, state encodings.
REQ-032 Decode SHALL be sub-module id_imm_decode (combinational: instr -> imm, mode, use_imm), instantiated once on the input path.
REQ-033 Buffer control and optional perf counter SHALL live in the top module.

Verification
REQ-034 ADDI imm 0x8000, out_ready=1 -> next cycle out_imm=0xFFFF8000, mode 00, use_imm=1.
REQ-035 ORI 0x8000, then LUI 0x1234, then SLL shamt 31 back-to-back -> 0x00008000/01, 0x12340000/10, 0x0000001F/11 in order, one per cycle.
REQ-036 out_ready=0, push 3 instrs -> two accepted, in_ready=0 on cycle 3; out_ready=1 -> both emerge FIFO, then third accepted.
REQ-037 TWO state, flush with in_valid=1 and out_ready=1 -> next cycle out_valid=0, in_ready=1, no output transfer, new instr dropped.
REQ-038 ADDU (R-type, non-shift) -> out_use_imm=0, out_imm=0; resetn=0 while in TWO -> EMPTY, all outputs zero.
REQ-039 IMM_SEQ_PERF_EN defined, out_ready=0 for 70000 cycles with valid entry -> perf_stall_cnt=0xFFFF, unchanged by flush, 0 after reset.
